// File: rtl/alu_issue_stage.sv
// ID/EX boundary for the ALU: decodes a MIPS word plus regfile operands and holds it
// in a head + skid register pair with valid/ready handshakes on both sides.
module alu_issue_stage #(
    parameter int unsigned DWIDTH    = 32,
    parameter int unsigned IMM_WIDTH = 16,
    parameter int unsigned PC_WIDTH  = 32
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_valid,
    output logic                 o_ready,
    input  logic [31:0]          i_instr,
    input  logic [DWIDTH-1:0]    i_data_rs,
    input  logic [DWIDTH-1:0]    i_data_rt,
    input  logic [PC_WIDTH-1:0]  i_pc,
    input  logic                 i_flush,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic [DWIDTH-1:0]    a_i_data_rs,
    output logic [DWIDTH-1:0]    a_i_data_rt,
    output logic [IMM_WIDTH-1:0] a_i_imm,
    output logic [4:0]           a_i_funct,
    output logic                 a_i_alu_src,
    output logic [PC_WIDTH-1:0]  a_i_pc,
    output logic [4:0]           o_wr_reg,
    output logic                 o_wr_en,
    output logic                 o_illegal
);

    typedef enum logic [4:0] {
        FN_ADD  = 5'd0,
        FN_SUB  = 5'd1,
        FN_AND  = 5'd2,
        FN_OR   = 5'd3,
        FN_XOR  = 5'd4,
        FN_NOR  = 5'd5,
        FN_SLT  = 5'd6,
        FN_SLTU = 5'd7,
        FN_SLL  = 5'd8,
        FN_SRL  = 5'd9,
        FN_SRA  = 5'd10,
        FN_LUI  = 5'd11,
        FN_BCMP = 5'd15
    } alu_fn_e;

    typedef enum logic [5:0] {
        OP_RTYPE = 6'h00,
        OP_BEQ   = 6'h04,
        OP_BNE   = 6'h05,
        OP_ADDI  = 6'h08,
        OP_ADDIU = 6'h09,
        OP_SLTI  = 6'h0A,
        OP_SLTIU = 6'h0B,
        OP_ANDI  = 6'h0C,
        OP_ORI   = 6'h0D,
        OP_XORI  = 6'h0E,
        OP_LUI   = 6'h0F,
        OP_LW    = 6'h23,
        OP_SW    = 6'h2B
    } opcode_e;

    typedef enum logic [5:0] {
        RF_SLL  = 6'h00,
        RF_SRL  = 6'h02,
        RF_SRA  = 6'h03,
        RF_ADD  = 6'h20,
        RF_ADDU = 6'h21,
        RF_SUB  = 6'h22,
        RF_SUBU = 6'h23,
        RF_AND  = 6'h24,
        RF_OR   = 6'h25,
        RF_XOR  = 6'h26,
        RF_NOR  = 6'h27,
        RF_SLT  = 6'h2A,
        RF_SLTU = 6'h2B
    } rfunct_e;

    typedef struct packed {
        logic [DWIDTH-1:0]    data_rs;
        logic [DWIDTH-1:0]    data_rt;
        logic [IMM_WIDTH-1:0] imm;
        alu_fn_e              funct;
        logic                 alu_src;
        logic [PC_WIDTH-1:0]  pc;
        logic [4:0]           wr_reg;
        logic                 wr_en;
        logic                 illegal;
    } entry_t;

    logic [5:0] opcode;
    logic [5:0] rfunct;
    entry_t     dec;
    entry_t     head;
    entry_t     skid;
    logic       head_valid;
    logic       skid_valid;
    logic       accept;
    logic       consume;
    // The rs index field is resolved by the regfile upstream; only its data arrives here.
    logic       unused_rs_field;

    assign opcode          = i_instr[31:26];
    assign rfunct          = i_instr[5:0];
    assign unused_rs_field = ^i_instr[25:21];

    always_comb begin
        dec         = '0;
        dec.data_rs = i_data_rs;
        dec.data_rt = i_data_rt;
        dec.pc      = i_pc;
        dec.imm     = IMM_WIDTH'(i_instr[15:0]);
        dec.funct   = FN_ADD;
        dec.alu_src = 1'b0;
        dec.wr_en   = 1'b0;
        dec.illegal = 1'b0;
        dec.wr_reg  = (opcode == OP_RTYPE) ? i_instr[15:11] : i_instr[20:16];
        case (opcode)
            OP_RTYPE: begin
                dec.wr_en = 1'b1;
                case (rfunct)
                    RF_ADD, RF_ADDU: dec.funct = FN_ADD;
                    RF_SUB, RF_SUBU: dec.funct = FN_SUB;
                    RF_AND:          dec.funct = FN_AND;
                    RF_OR:           dec.funct = FN_OR;
                    RF_XOR:          dec.funct = FN_XOR;
                    RF_NOR:          dec.funct = FN_NOR;
                    RF_SLT:          dec.funct = FN_SLT;
                    RF_SLTU:         dec.funct = FN_SLTU;
                    RF_SLL: begin
                        dec.funct = FN_SLL;
                        dec.imm   = IMM_WIDTH'(i_instr[10:6]);
                    end
                    RF_SRL: begin
                        dec.funct = FN_SRL;
                        dec.imm   = IMM_WIDTH'(i_instr[10:6]);
                    end
                    RF_SRA: begin
                        dec.funct = FN_SRA;
                        dec.imm   = IMM_WIDTH'(i_instr[10:6]);
                    end
                    default: begin
                        dec.illegal = 1'b1;
                        dec.wr_en   = 1'b0;
                    end
                endcase
            end
            OP_ADDI, OP_ADDIU, OP_LW: begin
                dec.funct   = FN_ADD;
                dec.alu_src = 1'b1;
                dec.wr_en   = 1'b1;
            end
            OP_SW: begin
                dec.funct   = FN_ADD;
                dec.alu_src = 1'b1;
            end
            OP_ANDI: begin
                dec.funct   = FN_AND;
                dec.alu_src = 1'b1;
                dec.wr_en   = 1'b1;
            end
            OP_ORI: begin
                dec.funct   = FN_OR;
                dec.alu_src = 1'b1;
                dec.wr_en   = 1'b1;
            end
            OP_XORI: begin
                dec.funct   = FN_XOR;
                dec.alu_src = 1'b1;
                dec.wr_en   = 1'b1;
            end
            OP_SLTI: begin
                dec.funct   = FN_SLT;
                dec.alu_src = 1'b1;
                dec.wr_en   = 1'b1;
            end
            OP_SLTIU: begin
                dec.funct   = FN_SLTU;
                dec.alu_src = 1'b1;
                dec.wr_en   = 1'b1;
            end
            OP_LUI: begin
                dec.funct   = FN_LUI;
                dec.alu_src = 1'b1;
                dec.wr_en   = 1'b1;
            end
            OP_BEQ, OP_BNE: begin
                dec.funct = FN_BCMP;
            end
            default: begin
                dec.illegal = 1'b1;
            end
        endcase
    end

    assign accept  = i_valid & ~skid_valid;
    assign consume = head_valid & i_ready;

    // skid_valid implies head_valid, so the head is always the oldest entry.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            head       <= '0;
            skid       <= '0;
            head_valid <= 1'b0;
            skid_valid <= 1'b0;
        end else if (i_flush) begin
            head_valid <= 1'b0;
            skid_valid <= 1'b0;
        end else if (skid_valid) begin
            if (consume) begin
                head       <= skid;
                skid_valid <= 1'b0;
            end
        end else if (head_valid) begin
            if (consume && accept) begin
                head <= dec;
            end else if (consume) begin
                head_valid <= 1'b0;
            end else if (accept) begin
                skid       <= dec;
                skid_valid <= 1'b1;
            end
        end else if (accept) begin
            head       <= dec;
            head_valid <= 1'b1;
        end
    end

    assign o_valid     = head_valid;
    assign o_ready     = ~skid_valid;
    assign a_i_data_rs = head.data_rs;
    assign a_i_data_rt = head.data_rt;
    assign a_i_imm     = head.imm;
    assign a_i_funct   = head.funct;
    assign a_i_alu_src = head.alu_src;
    assign a_i_pc      = head.pc;
    assign o_wr_reg    = head.wr_reg;
    assign o_wr_en     = head.wr_en;
    assign o_illegal   = head.illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Scoreboard bench for alu_issue_stage: accepted words are decoded by a table-driven
// reference model and queued; a negedge monitor checks occupancy and head contents.
module tb_alu_issue_stage;

    logic        clk;
    logic        rst_n;
    logic        i_valid;
    logic        o_ready;
    logic [31:0] i_instr;
    logic [31:0] i_data_rs;
    logic [31:0] i_data_rt;
    logic [31:0] i_pc;
    logic        i_flush;
    logic        o_valid;
    logic        i_ready;
    logic [31:0] a_i_data_rs;
    logic [31:0] a_i_data_rt;
    logic [15:0] a_i_imm;
    logic [4:0]  a_i_funct;
    logic        a_i_alu_src;
    logic [31:0] a_i_pc;
    logic [4:0]  o_wr_reg;
    logic        o_wr_en;
    logic        o_illegal;

    alu_issue_stage #(.DWIDTH(32), .IMM_WIDTH(16), .PC_WIDTH(32)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_valid     (i_valid),
        .o_ready     (o_ready),
        .i_instr     (i_instr),
        .i_data_rs   (i_data_rs),
        .i_data_rt   (i_data_rt),
        .i_pc        (i_pc),
        .i_flush     (i_flush),
        .o_valid     (o_valid),
        .i_ready     (i_ready),
        .a_i_data_rs (a_i_data_rs),
        .a_i_data_rt (a_i_data_rt),
        .a_i_imm     (a_i_imm),
        .a_i_funct   (a_i_funct),
        .a_i_alu_src (a_i_alu_src),
        .a_i_pc      (a_i_pc),
        .o_wr_reg    (o_wr_reg),
        .o_wr_en     (o_wr_en),
        .o_illegal   (o_illegal)
    );

    typedef struct packed {
        logic [31:0] rs;
        logic [31:0] rt;
        logic [15:0] imm;
        logic [4:0]  fn;
        logic        src;
        logic [31:0] pc;
        logic [4:0]  wr_reg;
        logic        wr_en;
        logic        ill;
    } exp_t;

    int   checks = 0;
    int   failures = 0;
    int   n_out = 0;
    exp_t sb[$];
    exp_t last_head = '0;
    exp_t act;
    int   r_tab[int];
    int   i_tab[int];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] a, input logic [127:0] e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, a, e);
        end
    endtask

    // Reference decode: lookup tables keyed by MIPS funct / opcode.
    function automatic exp_t model(input logic [31:0] ins, input logic [31:0] rs,
                                   input logic [31:0] rt, input logic [31:0] pc);
        exp_t e;
        int op;
        int fn;
        op = int'(ins[31:26]);
        fn = int'(ins[5:0]);
        e.rs     = rs;
        e.rt     = rt;
        e.pc     = pc;
        e.imm    = ins[15:0];
        e.fn     = 5'd0;
        e.src    = 1'b0;
        e.wr_en  = 1'b0;
        e.ill    = 1'b0;
        e.wr_reg = (op == 0) ? ins[15:11] : ins[20:16];
        if (op == 0) begin
            if (r_tab.exists(fn)) begin
                e.fn    = 5'(r_tab[fn]);
                e.wr_en = 1'b1;
                if (fn < 4) e.imm = {11'b0, ins[10:6]};
            end else begin
                e.ill = 1'b1;
            end
        end else if (op == 4 || op == 5) begin
            e.fn = 5'd15;
        end else if (i_tab.exists(op)) begin
            e.fn    = 5'(i_tab[op]);
            e.src   = 1'b1;
            e.wr_en = (op != 'h2B);
        end else begin
            e.ill = 1'b1;
        end
        return e;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [5:0]  ops[16] = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h08, 6'h09, 6'h0C, 6'h0D,
                                  6'h0E, 6'h0A, 6'h0B, 6'h0F, 6'h23, 6'h2B, 6'h04, 6'h05};
        logic [5:0]  fns[13] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                                  6'h2A, 6'h2B, 6'h00, 6'h02, 6'h03};
        logic [31:0] w;
        int          p;
        w = $urandom;
        p = $urandom_range(0, 19);
        if (p < 16) w[31:26] = ops[p];
        if (w[31:26] == 6'h00 && $urandom_range(0, 7) != 0) w[5:0] = fns[$urandom_range(0, 12)];
        return w;
    endfunction

    // Stimulus-side scoreboard push: a word is accepted at the coming edge.
    always begin
        @(posedge clk);
        #8;
        if (rst_n && !i_flush && i_valid && o_ready)
            sb.push_back(model(i_instr, i_data_rs, i_data_rt, i_pc));
    end

    // Monitor: occupancy, head contents, hold-when-idle, then consume/flush.
    always @(negedge clk) begin
        if (rst_n) begin
            act = {a_i_data_rs, a_i_data_rt, a_i_imm, a_i_funct, a_i_alu_src,
                   a_i_pc, o_wr_reg, o_wr_en, o_illegal};
            chk("o_valid", o_valid, sb.size() != 0);
            chk("o_ready", o_ready, sb.size() < 2);
            if (o_valid && sb.size() != 0) begin
                chk("head_entry", act, sb[0]);
                last_head = sb[0];
            end else if (!o_valid) begin
                chk("idle_hold", act, last_head);
            end
            if (i_flush) begin
                sb.delete();
            end else if (o_valid && i_ready && sb.size() != 0) begin
                void'(sb.pop_front());
                n_out++;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic send(input logic [31:0] ins, input logic [31:0] rs,
                        input logic [31:0] rt, input logic [31:0] pc);
        bit done;
        done      = 1'b0;
        i_valid   = 1'b1;
        i_instr   = ins;
        i_data_rs = rs;
        i_data_rt = rt;
        i_pc      = pc;
        for (int k = 0; k < 50 && !done; k++) begin
            @(negedge clk);
            done = o_ready;
            step();
        end
        i_valid = 1'b0;
        if (!done) chk("send_timeout", 0, 1);
    endtask

    initial begin
        bit   took;
        int   base;

        r_tab['h20] = 0;  r_tab['h21] = 0;  r_tab['h22] = 1;  r_tab['h23] = 1;
        r_tab['h24] = 2;  r_tab['h25] = 3;  r_tab['h26] = 4;  r_tab['h27] = 5;
        r_tab['h2A] = 6;  r_tab['h2B] = 7;  r_tab['h00] = 8;  r_tab['h02] = 9;
        r_tab['h03] = 10;
        i_tab['h08] = 0;  i_tab['h09] = 0;  i_tab['h0C] = 2;  i_tab['h0D] = 3;
        i_tab['h0E] = 4;  i_tab['h0A] = 6;  i_tab['h0B] = 7;  i_tab['h0F] = 11;
        i_tab['h23] = 0;  i_tab['h2B] = 0;

        rst_n = 1'b1; i_valid = 1'b0; i_instr = '0; i_data_rs = '0; i_data_rt = '0;
        i_pc = '0; i_flush = 1'b0; i_ready = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        chk("reset_o_valid", o_valid, 0);
        chk("reset_o_ready", o_ready, 1);
        chk("reset_funct", a_i_funct, 0);
        chk("reset_data", {a_i_data_rs, a_i_data_rt, a_i_imm, a_i_pc, o_wr_en, o_illegal}, 0);
        @(posedge clk);
        @(posedge clk);
        #3 rst_n = 1'b1;
        step();

        i_ready = 1'b1;
        send({6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20}, 32'd5, 32'd4, 32'd10);
        chk("add_valid", o_valid, 1);
        chk("add_fields", {a_i_funct, a_i_alu_src, a_i_data_rs, a_i_data_rt, o_wr_reg, o_wr_en},
            {5'd0, 1'b0, 32'd5, 32'd4, 5'd3, 1'b1});
        send({6'h08, 5'd1, 5'd2, 16'd10}, 32'd7, 32'd8, 32'd14);
        chk("addi_fields", {a_i_funct, a_i_alu_src, a_i_imm, o_wr_reg}, {5'd0, 1'b1, 16'd10, 5'd2});
        send({6'h04, 5'd1, 5'd2, 16'd3}, 32'd1, 32'd1, 32'd18);
        chk("beq_fields", {a_i_funct, a_i_alu_src, o_wr_en}, {5'd15, 1'b0, 1'b0});
        send({6'h00, 5'd0, 5'd5, 5'd4, 5'd7, 6'h00}, 32'd0, 32'h80, 32'd22);
        chk("sll_fields", {a_i_funct, a_i_alu_src, a_i_imm}, {5'd8, 1'b0, 16'd7});
        send({6'h3F, 26'h123456}, 32'd9, 32'd9, 32'd26);
        chk("illegal_fields", {o_illegal, o_wr_en, a_i_funct}, {1'b1, 1'b0, 5'd0});
        repeat (3) step();

        // Stall: two words fill both entries, a third is held off until release.
        base = n_out;
        i_ready = 1'b0;
        send({6'h00, 5'd1, 5'd2, 5'd10, 5'd0, 6'h22}, 32'd100, 32'd1, 32'h40);
        send({6'h0D, 5'd3, 5'd11, 16'h00FF}, 32'd200, 32'd2, 32'h44);
        chk("stall_o_ready", o_ready, 0);
        i_valid = 1'b1; i_instr = {6'h0F, 5'd0, 5'd12, 16'hBEEF};
        i_data_rs = 32'd300; i_data_rt = 32'd3; i_pc = 32'h48;
        repeat (3) step();
        chk("stall_still_full", {o_ready, o_valid}, 2'b01);
        i_ready = 1'b1;
        send({6'h0F, 5'd0, 5'd12, 16'hBEEF}, 32'd300, 32'd3, 32'h48);
        repeat (4) step();
        chk("stall_exit_count", n_out - base, 3);

        // Flush with both entries full, simultaneous offer and consume.
        base = n_out;
        i_ready = 1'b0;
        send({6'h00, 5'd1, 5'd2, 5'd13, 5'd0, 6'h24}, 32'd11, 32'd12, 32'h80);
        send({6'h00, 5'd1, 5'd2, 5'd14, 5'd0, 6'h25}, 32'd13, 32'd14, 32'h84);
        i_valid = 1'b1; i_instr = {6'h09, 5'd1, 5'd15, 16'd5}; i_pc = 32'h88;
        i_flush = 1'b1; i_ready = 1'b1;
        step();
        i_flush = 1'b0; i_valid = 1'b0;
        chk("flush_state", {o_valid, o_ready}, 2'b01);
        chk("flush_nothing_issued", n_out - base, 0);
        step();

        // Asynchronous reset between edges with both entries occupied.
        i_ready = 1'b0;
        send({6'h23, 5'd1, 5'd16, 16'h0010}, 32'h55, 32'h66, 32'hC0);
        send({6'h2B, 5'd1, 5'd17, 16'h0020}, 32'h77, 32'h88, 32'hC4);
        #1 rst_n = 1'b0;
        #1;
        chk("midreset_state", {o_valid, o_ready}, 2'b01);
        chk("midreset_data", {a_i_data_rs, a_i_pc, a_i_funct}, 0);
        sb.delete();
        last_head = '0;
        step();
        step();
        #1 rst_n = 1'b1;
        step();

        // Randomized valid/ready/flush traffic with a holding upstream.
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            took = i_valid && o_ready && !i_flush;
            step();
            i_flush = ($urandom_range(0, 99) == 0);
            i_ready = ($urandom_range(0, 99) < 65);
            if (took || !i_valid) begin
                i_valid   = ($urandom_range(0, 3) != 0);
                i_instr   = rand_instr();
                i_data_rs = $urandom;
                i_data_rt = $urandom;
                i_pc      = $urandom;
            end
        end
        i_valid = 1'b0; i_flush = 1'b0; i_ready = 1'b1;
        repeat (4) step();
        chk("drained", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
